vram_responder: RTL and testbench
=================================

# vram_responder

FPGA-side emulation of the two SNES VRAM byte planes (A and B) as a bus responder. It watches the asynchronous PPU strobes vrd_n, vawr_n and vbwr_n, commits writes into internal block RAM and drives read data back onto vda/vdb through the existing bidirectional pin cells. A host peek port lets the UART command layer read emulated VRAM contents for bringup checks.

## Interface
- ADDR_BITS, 15: plane depth is 2^ADDR_BITS bytes; address = {va14, vaX[ADDR_BITS-2:0]}
- COUNT_BITS, 16: width of the read and write cycle counters
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- vrd_n  input  1  PPU read strobe, asynchronous to clock
- vawr_n  input  1  plane A write strobe, asynchronous
- vbwr_n  input  1  plane B write strobe, asynchronous
- va14  input  1  shared address MSB
- vaa  input  14  plane A address
- vab  input  14  plane B address
- vda_i  input  8  plane A data from pin cell
- vdb_i  input  8  plane B data from pin cell
- vda_o  output  8  plane A read data to pin cell
- vdb_o  output  8  plane B read data to pin cell
- vd_dir  output  1  LVL_DIR_OUTPUT while driving read data, else LVL_DIR_INPUT
- peek_addr_i  input  ADDR_BITS  host read address
- peek_valid_i  input  1  host read request
- peek_ready_o  output  1  request accepted when valid && ready
- peek_data_o  output  16  {plane B, plane A} read result
- peek_valid_o  output  1  one-cycle pulse, peek_data_o valid
- read_count_o  output  COUNT_BITS  completed bus reads, wraps
- write_count_o  output  COUNT_BITS  completed bus writes, wraps
- error_overlap_o  output  1  sticky: read and write strobe asserted together

## Operation
- Strobes pass through 2-FF synchronizers (reset to 1). Address/data buses pass through a matching 2-stage delay so they align with the synchronized strobes.
- States: IDLE, READ_FETCH, READ_DRIVE, WRITE_ACTIVE, PEEK.
- IDLE: vd_dir = LVL_DIR_INPUT.
  - rd low, both wr high: issue RAM read at the delayed address, go to READ_FETCH.
  - Any wr low, rd high: go to WRITE_ACTIVE.
  - rd and any wr low: set error_overlap_o and stay in IDLE; no RAM access.
  - All strobes high and peek_valid_i: accept the peek, issue a RAM read, go to PEEK.
- READ_FETCH: load vda_o/vdb_o from RAM, go to READ_DRIVE.
- READ_DRIVE: vd_dir = LVL_DIR_OUTPUT.
  - Synced rd high: go to IDLE, increment read_count_o.
  - Any wr seen low here: set error_overlap_o; remain until rd is high.
- WRITE_ACTIVE: each cycle, capture the delayed address/data and OR-accumulate per-plane "strobe seen" flags.
  - When both wr are high, commit: write the planes whose flag is set, using the last captured values; increment write_count_o once; clear flags; go to IDLE.
  - rd low during WRITE_ACTIVE: set error_overlap_o and suppress the commit.
- PEEK: peek_data_o = {B, A}, peek_valid_o = 1 for one cycle, go to IDLE.
- peek_ready_o = (state == IDLE) && all synced strobes high. Bus activity always has priority over peek.
- Address is sampled once per read; mid-strobe address changes are ignored.

## Timing
- Reset values: vd_dir = LVL_DIR_INPUT; vda_o, vdb_o, peek_data_o, counters = 0; peek_valid_o, error_overlap_o = 0; state = IDLE. Reset mid-cycle releases the bus immediately (async).
- Read: vd_dir switches to output 4 clocks after the vrd_n pin falls (2 sync, 1 IDLE, 1 fetch). It releases 3 clocks after vrd_n rises.
- Write: RAM is updated 3 clocks after the last write strobe rises.
- Peek: peek_valid_o pulses 2 clocks after acceptance.
- Strobes low for fewer than 2 clocks may be missed; this is the defined limitation.
- Counters wrap from all-ones to 0.

## Structure
- Shared package: LVL_DIR_INPUT/LVL_DIR_OUTPUT, state encodings.
- Sub-module vram_plane: 2^ADDR_BITS x 8 RAM with registered read and a single write port, instantiated twice.

## Test plan
- vawr_n low 6 clocks, addr 0x0123, vda 0xA5, then peek 0x0123 -> peek_data_o = 0x00A5, write_count_o = 1.
- vbwr_n only, addr 0x7FFF (va14 = 1), vdb 0x3C -> peek 0x7FFF = 0x3C00; plane A unchanged.
- Write 0x5A/0xC3 at 0x0040, then vrd_n low 8 clocks -> vd_dir output 4 clocks after the fall, vda_o = 0x5A, vdb_o = 0xC3, released 3 clocks after the rise, read_count_o = 1.
- vrd_n and vawr_n low together -> error_overlap_o = 1, no write, vd_dir stays input.
- peek_valid_i held during a bus read -> peek_ready_o = 0 until IDLE; data returned afterwards is correct.
- Reset asserted in READ_DRIVE -> vd_dir = input immediately, counters = 0.

Source files
------------

// File: rtl/vram_responder_pkg.sv
// Shared constants for the VRAM responder: level-shifter direction codes,
// FSM state encodings and the synchronized strobe bundle.
package vram_responder_pkg;

  localparam logic LVL_DIR_INPUT  = 1'b0;
  localparam logic LVL_DIR_OUTPUT = 1'b1;

  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_READ_FETCH   = 3'd1;
  localparam logic [2:0] ST_READ_DRIVE   = 3'd2;
  localparam logic [2:0] ST_WRITE_ACTIVE = 3'd3;
  localparam logic [2:0] ST_PEEK         = 3'd4;

  typedef struct packed {
    logic rd_n;
    logic awr_n;
    logic bwr_n;
  } strobes_t;

  function automatic logic any_wr_low(input strobes_t s);
    return !s.awr_n || !s.bwr_n;
  endfunction

endpackage

// File: rtl/vram_plane.sv
// One 8-bit VRAM byte plane: single port, registered read, write wins.
module vram_plane #(
  parameter int ADDR_BITS = 15
) (
  input  logic                 clock,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 rd_en,
  input  logic                 wr_en,
  input  logic [7:0]           wr_data,
  output logic [7:0]           rd_data
);

  logic [7:0] mem [0:(1<<ADDR_BITS)-1];

  // Synchronous write, or registered read when no write is pending.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end else if (rd_en) begin
      rd_data <= mem[addr];
    end
  end

endmodule

// File: rtl/vram_responder.sv
// SNES VRAM bus responder: emulates planes A/B in block RAM, answers PPU
// reads/writes seen on asynchronous strobes, and offers a host peek port.
module vram_responder #(
  parameter int ADDR_BITS  = 15,
  parameter int COUNT_BITS = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  vrd_n,
  input  logic                  vawr_n,
  input  logic                  vbwr_n,
  input  logic                  va14,
  input  logic [13:0]           vaa,
  input  logic [13:0]           vab,
  input  logic [7:0]            vda_i,
  input  logic [7:0]            vdb_i,
  output logic [7:0]            vda_o,
  output logic [7:0]            vdb_o,
  output logic                  vd_dir,
  input  logic [ADDR_BITS-1:0]  peek_addr_i,
  input  logic                  peek_valid_i,
  output logic                  peek_ready_o,
  output logic [15:0]           peek_data_o,
  output logic                  peek_valid_o,
  output logic [COUNT_BITS-1:0] read_count_o,
  output logic [COUNT_BITS-1:0] write_count_o,
  output logic                  error_overlap_o
);

  import vram_responder_pkg::*;

  strobes_t       strb_p0, strb_p1;
  logic           va14_p0, va14_p1;
  logic [13:0]    vaa_p0, vaa_p1, vab_p0, vab_p1;
  logic [7:0]     vda_p0, vda_p1, vdb_p0, vdb_p1;

  logic [2:0]     state_q, state_d;
  logic           seen_a, seen_b, suppress;
  logic [ADDR_BITS-1:0] cap_addr_a, cap_addr_b;
  logic [7:0]     cap_data_a, cap_data_b;

  logic [ADDR_BITS-1:0] addr_a_p1, addr_b_p1, ram_addr_a, ram_addr_b;
  logic           rd_en, we_a, we_b, commit, overlap, cap_en, wa_exit;
  logic [7:0]     ram_q_a, ram_q_b;
  logic           rd_low, wr_low;

  assign addr_a_p1 = {va14_p1, vaa_p1[ADDR_BITS-2:0]};
  assign addr_b_p1 = {va14_p1, vab_p1[ADDR_BITS-2:0]};
  assign rd_low    = !strb_p1.rd_n;
  assign wr_low    = any_wr_low(strb_p1);

  // Stage p0/p1: two-flop synchronizers for the strobes, idle-high out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      strb_p0 <= '1;
      strb_p1 <= '1;
    end else begin
      strb_p0 <= strobes_t'({vrd_n, vawr_n, vbwr_n});
      strb_p1 <= strb_p0;
    end
  end

  // Stage p0/p1: matching delay on address/data so they line up with the strobes.
  always_ff @(posedge clock) begin
    va14_p0 <= va14;
    vaa_p0  <= vaa;
    vab_p0  <= vab;
    vda_p0  <= vda_i;
    vdb_p0  <= vdb_i;
    va14_p1 <= va14_p0;
    vaa_p1  <= vaa_p0;
    vab_p1  <= vab_p0;
    vda_p1  <= vda_p0;
    vdb_p1  <= vdb_p0;
  end

  // Next-state decode and RAM port control; bus strobes outrank peek.
  always_comb begin
    state_d    = state_q;
    ram_addr_a = addr_a_p1;
    ram_addr_b = addr_b_p1;
    rd_en      = 1'b0;
    we_a       = 1'b0;
    we_b       = 1'b0;
    commit     = 1'b0;
    overlap    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rd_low && wr_low) begin
          overlap = 1'b1;
        end else if (rd_low) begin
          rd_en   = 1'b1;
          state_d = ST_READ_FETCH;
        end else if (wr_low) begin
          state_d = ST_WRITE_ACTIVE;
        end else if (peek_valid_i) begin
          ram_addr_a = peek_addr_i;
          ram_addr_b = peek_addr_i;
          rd_en      = 1'b1;
          state_d    = ST_PEEK;
        end
      end
      ST_READ_FETCH: state_d = ST_READ_DRIVE;
      ST_READ_DRIVE: begin
        if (wr_low) overlap = 1'b1;
        if (!rd_low) state_d = ST_IDLE;
      end
      ST_WRITE_ACTIVE: begin
        if (rd_low) overlap = 1'b1;
        if (!wr_low) begin
          state_d = ST_IDLE;
          if (!suppress && !rd_low) begin
            commit     = 1'b1;
            we_a       = seen_a;
            we_b       = seen_b;
            ram_addr_a = cap_addr_a;
            ram_addr_b = cap_addr_b;
          end
        end
      end
      ST_PEEK: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Write capture is open on the IDLE->write transition and throughout WRITE_ACTIVE.
  assign cap_en  = (state_q == ST_IDLE && !rd_low && wr_low) || (state_q == ST_WRITE_ACTIVE);
  assign wa_exit = (state_q == ST_WRITE_ACTIVE) && !wr_low;

  // Latest address/data per plane while that plane's strobe is low.
  always_ff @(posedge clock) begin
    if (cap_en && !strb_p1.awr_n) begin
      cap_addr_a <= addr_a_p1;
      cap_data_a <= vda_p1;
    end
    if (cap_en && !strb_p1.bwr_n) begin
      cap_addr_b <= addr_b_p1;
      cap_data_b <= vdb_p1;
    end
  end

  // FSM state, write bookkeeping, bus/peek outputs, counters and sticky error.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      seen_a          <= 1'b0;
      seen_b          <= 1'b0;
      suppress        <= 1'b0;
      vda_o           <= '0;
      vdb_o           <= '0;
      peek_data_o     <= '0;
      peek_valid_o    <= 1'b0;
      read_count_o    <= '0;
      write_count_o   <= '0;
      error_overlap_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      peek_valid_o <= (state_q == ST_PEEK);
      if (overlap) error_overlap_o <= 1'b1;
      if (wa_exit) begin
        seen_a   <= 1'b0;
        seen_b   <= 1'b0;
        suppress <= 1'b0;
      end else if (cap_en) begin
        seen_a   <= seen_a | !strb_p1.awr_n;
        seen_b   <= seen_b | !strb_p1.bwr_n;
        suppress <= suppress | (state_q == ST_WRITE_ACTIVE && rd_low);
      end
      if (state_q == ST_READ_FETCH) begin
        vda_o <= ram_q_a;
        vdb_o <= ram_q_b;
      end
      if (state_q == ST_PEEK) peek_data_o <= {ram_q_b, ram_q_a};
      if (state_q == ST_READ_DRIVE && !rd_low) read_count_o <= read_count_o + COUNT_BITS'(1);
      if (commit) write_count_o <= write_count_o + COUNT_BITS'(1);
    end
  end

  assign vd_dir       = (state_q == ST_READ_DRIVE) ? LVL_DIR_OUTPUT : LVL_DIR_INPUT;
  assign peek_ready_o = (state_q == ST_IDLE) && strb_p1.rd_n && strb_p1.awr_n && strb_p1.bwr_n;

  vram_plane #(.ADDR_BITS(ADDR_BITS)) u_plane_a (
    .clock   (clock),
    .addr    (ram_addr_a),
    .rd_en   (rd_en),
    .wr_en   (we_a),
    .wr_data (cap_data_a),
    .rd_data (ram_q_a)
  );

  vram_plane #(.ADDR_BITS(ADDR_BITS)) u_plane_b (
    .clock   (clock),
    .addr    (ram_addr_b),
    .rd_en   (rd_en),
    .wr_en   (we_b),
    .wr_data (cap_data_b),
    .rd_data (ram_q_b)
  );

endmodule

// File: tb/tb_vram_responder.sv
// Bench for vram_responder: directed scenarios plus randomized bus/peek
// traffic checked against a transaction-level memory and counter model.
module tb_vram_responder;
  import vram_responder_pkg::*;

  localparam int AB = 15;
  localparam int CB = 4;

  logic          clock, reset;
  logic          vrd_n, vawr_n, vbwr_n, va14;
  logic [13:0]   vaa, vab;
  logic [7:0]    vda_i, vdb_i, vda_o, vdb_o;
  logic          vd_dir;
  logic [AB-1:0] peek_addr_i;
  logic          peek_valid_i, peek_ready_o, peek_valid_o;
  logic [15:0]   peek_data_o;
  logic [CB-1:0] read_count_o, write_count_o;
  logic          error_overlap_o;

  int total = 0;
  int bad   = 0;
  int rcnt  = 0;
  int wcnt  = 0;
  logic [7:0] ma [logic [AB-1:0]];
  logic [7:0] mb [logic [AB-1:0]];
  logic [13:0] pool [8];

  vram_responder #(.ADDR_BITS(AB), .COUNT_BITS(CB)) dut (
    .clock           (clock),
    .reset           (reset),
    .vrd_n           (vrd_n),
    .vawr_n          (vawr_n),
    .vbwr_n          (vbwr_n),
    .va14            (va14),
    .vaa             (vaa),
    .vab             (vab),
    .vda_i           (vda_i),
    .vdb_i           (vdb_i),
    .vda_o           (vda_o),
    .vdb_o           (vdb_o),
    .vd_dir          (vd_dir),
    .peek_addr_i     (peek_addr_i),
    .peek_valid_i    (peek_valid_i),
    .peek_ready_o    (peek_ready_o),
    .peek_data_o     (peek_data_o),
    .peek_valid_o    (peek_valid_o),
    .read_count_o    (read_count_o),
    .write_count_o   (write_count_o),
    .error_overlap_o (error_overlap_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] mask, input logic v14, input logic [13:0] a_lo,
                           input logic [13:0] b_lo, input logic [7:0] da, input logic [7:0] db,
                           input int low_cyc);
    va14 = v14; vaa = a_lo; vab = b_lo; vda_i = da; vdb_i = db;
    vawr_n = !mask[0];
    vbwr_n = !mask[1];
    tick(low_cyc);
    vawr_n = 1'b1;
    vbwr_n = 1'b1;
    tick(4);
    if (mask[0]) ma[{v14, a_lo}] = da;
    if (mask[1]) mb[{v14, b_lo}] = db;
    wcnt = (wcnt + 1) % (1 << CB);
    check("wr_count", 32'(write_count_o), 32'(wcnt));
  endtask

  task automatic bus_read(input logic v14, input logic [13:0] a_lo, input logic [13:0] b_lo,
                          input int low_cyc);
    va14 = v14; vaa = a_lo; vab = b_lo;
    vrd_n = 1'b0;
    tick(3);
    check("rd_dir_early", 32'(vd_dir), 32'(LVL_DIR_INPUT));
    tick(1);
    check("rd_dir_on", 32'(vd_dir), 32'(LVL_DIR_OUTPUT));
    check("rd_vda", 32'(vda_o), 32'(ma[{v14, a_lo}]));
    check("rd_vdb", 32'(vdb_o), 32'(mb[{v14, b_lo}]));
    tick(low_cyc - 4);
    vrd_n = 1'b1;
    tick(2);
    check("rd_dir_hold", 32'(vd_dir), 32'(LVL_DIR_OUTPUT));
    tick(1);
    check("rd_dir_off", 32'(vd_dir), 32'(LVL_DIR_INPUT));
    rcnt = (rcnt + 1) % (1 << CB);
    check("rd_count", 32'(read_count_o), 32'(rcnt));
  endtask

  task automatic do_peek(input logic [AB-1:0] a);
    peek_addr_i  = a;
    peek_valid_i = 1'b1;
    check("pk_ready", 32'(peek_ready_o), 32'd1);
    tick(1);
    peek_valid_i = 1'b0;
    check("pk_valid_early", 32'(peek_valid_o), 32'd0);
    tick(1);
    check("pk_valid", 32'(peek_valid_o), 32'd1);
    check("pk_data", 32'(peek_data_o), 32'({mb[a], ma[a]}));
    tick(1);
    check("pk_valid_drop", 32'(peek_valid_o), 32'd0);
  endtask

  initial begin
    logic [1:0]  mask;
    logic        v14;
    int          ia, ib, op;

    reset = 1'b0;
    vrd_n = 1'b1; vawr_n = 1'b1; vbwr_n = 1'b1;
    va14 = 1'b0; vaa = '0; vab = '0; vda_i = '0; vdb_i = '0;
    peek_addr_i = '0; peek_valid_i = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(3);

    // Reset state
    check("rst_dir", 32'(vd_dir), 32'(LVL_DIR_INPUT));
    check("rst_vda", 32'(vda_o), 32'd0);
    check("rst_vdb", 32'(vdb_o), 32'd0);
    check("rst_peek_data", 32'(peek_data_o), 32'd0);
    check("rst_peek_valid", 32'(peek_valid_o), 32'd0);
    check("rst_rcnt", 32'(read_count_o), 32'd0);
    check("rst_wcnt", 32'(write_count_o), 32'd0);
    check("rst_err", 32'(error_overlap_o), 32'd0);
    check("rst_ready", 32'(peek_ready_o), 32'd1);

    // Plane A write only, then fill B so the peek word is fully defined
    bus_write(2'b01, 1'b0, 14'h0123, 14'h0000, 8'hA5, 8'h00, 6);
    bus_write(2'b10, 1'b0, 14'h0000, 14'h0123, 8'h00, 8'h00, 4);
    do_peek(15'h0123);
    check("pk_0123", 32'(peek_data_o), 32'h00A5);

    // Top address, plane B only must leave plane A alone
    bus_write(2'b11, 1'b1, 14'h3FFF, 14'h3FFF, 8'h11, 8'h22, 5);
    bus_write(2'b10, 1'b1, 14'h3FFF, 14'h3FFF, 8'hEE, 8'h3C, 5);
    do_peek(15'h7FFF);
    check("pk_7fff", 32'(peek_data_o), 32'h3C11);

    // Directed read with the exact turn-on/turn-off timing
    bus_write(2'b11, 1'b0, 14'h0040, 14'h0040, 8'h5A, 8'hC3, 5);
    bus_read(1'b0, 14'h0040, 14'h0040, 8);
    check("rd_5a", 32'(vda_o), 32'h5A);
    check("rd_c3", 32'(vdb_o), 32'hC3);
    check("err_clean", 32'(error_overlap_o), 32'd0);

    // Read and write strobes together: flagged, nothing written, bus not driven
    va14 = 1'b0; vaa = 14'h0040; vda_i = 8'hFF;
    vrd_n = 1'b0; vawr_n = 1'b0;
    tick(4);
    check("ovl_dir", 32'(vd_dir), 32'(LVL_DIR_INPUT));
    tick(2);
    check("ovl_err", 32'(error_overlap_o), 32'd1);
    check("ovl_dir2", 32'(vd_dir), 32'(LVL_DIR_INPUT));
    vrd_n = 1'b1; vawr_n = 1'b1;
    tick(4);
    check("ovl_wcnt", 32'(write_count_o), 32'(wcnt));
    check("ovl_rcnt", 32'(read_count_o), 32'(rcnt));
    do_peek(15'h0040);
    check("ovl_nowrite", 32'(peek_data_o), 32'hC35A);

    // Peek request held across a bus read
    va14 = 1'b0; vaa = 14'h0040; vab = 14'h0040;
    vrd_n = 1'b0;
    tick(2);
    peek_addr_i = 15'h0123;
    peek_valid_i = 1'b1;
    check("pdr_ready0", 32'(peek_ready_o), 32'd0);
    tick(2);
    check("pdr_dir", 32'(vd_dir), 32'(LVL_DIR_OUTPUT));
    check("pdr_ready1", 32'(peek_ready_o), 32'd0);
    check("pdr_vda", 32'(vda_o), 32'h5A);
    tick(4);
    vrd_n = 1'b1;
    tick(2);
    check("pdr_ready2", 32'(peek_ready_o), 32'd0);
    check("pdr_novalid", 32'(peek_valid_o), 32'd0);
    tick(1);
    check("pdr_ready3", 32'(peek_ready_o), 32'd1);
    check("pdr_dir_off", 32'(vd_dir), 32'(LVL_DIR_INPUT));
    rcnt = (rcnt + 1) % (1 << CB);
    check("pdr_rcnt", 32'(read_count_o), 32'(rcnt));
    tick(1);
    peek_valid_i = 1'b0;
    tick(1);
    check("pdr_valid", 32'(peek_valid_o), 32'd1);
    check("pdr_data", 32'(peek_data_o), 32'h00A5);
    tick(1);

    // Random traffic over a pool of addresses, both va14 halves initialised first
    for (int i = 0; i < 8; i++) pool[i] = 14'($urandom_range(0, 16383));
    for (int h = 0; h < 2; h++) begin
      for (int i = 0; i < 8; i++) begin
        bus_write(2'b11, 1'(h), pool[i], pool[i], 8'($urandom), 8'($urandom), 3);
      end
    end
    for (int n = 0; n < 60; n++) begin
      op  = int'($urandom_range(0, 2));
      v14 = 1'($urandom_range(0, 1));
      ia  = int'($urandom_range(0, 7));
      ib  = int'($urandom_range(0, 7));
      if (op == 0) begin
        mask = 2'($urandom_range(1, 3));
        bus_write(mask, v14, pool[ia], pool[ib], 8'($urandom), 8'($urandom),
                  int'($urandom_range(3, 6)));
      end else if (op == 1) begin
        bus_read(v14, pool[ia], pool[ib], int'($urandom_range(4, 8)));
      end else begin
        do_peek({v14, pool[ia]});
      end
    end
    check("err_sticky", 32'(error_overlap_o), 32'd1);

    // Asynchronous reset while driving read data
    va14 = 1'b0; vaa = 14'h0040; vab = 14'h0040;
    vrd_n = 1'b0;
    tick(6);
    check("rstrd_dir_pre", 32'(vd_dir), 32'(LVL_DIR_OUTPUT));
    reset = 1'b0;
    #1;
    check("rstrd_dir", 32'(vd_dir), 32'(LVL_DIR_INPUT));
    check("rstrd_rcnt", 32'(read_count_o), 32'd0);
    check("rstrd_wcnt", 32'(write_count_o), 32'd0);
    check("rstrd_vda", 32'(vda_o), 32'd0);
    check("rstrd_err", 32'(error_overlap_o), 32'd0);
    vrd_n = 1'b1;
    tick(2);
    reset = 1'b1;
    rcnt = 0;
    wcnt = 0;
    tick(3);
    do_peek(15'h0123);
    bus_read(1'b0, 14'h0040, 14'h0040, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
